// File: rtl/pulse_width_mon.sv
// Multi-channel pulse-width monitor: classifies each high run as pass / too short / too long.
// Optional per-channel error counters are built when PULSE_WIDTH_MON_ERR_CNT_EN is defined.
module pulse_width_mon #(
   parameter int NUM_CH    = 4,
   parameter int CNT_W     = 8,
   parameter int MIN_CKS   = 1,
   parameter int MAX_CKS   = 4,
   parameter int UNBOUNDED = 0
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [NUM_CH-1:0]       expr,
   input  logic [NUM_CH-1:0]       ch_en,
   input  logic                    err_clr,
   output logic [NUM_CH-1:0]       pass,
   output logic [NUM_CH-1:0]       err_short,
   output logic [NUM_CH-1:0]       err_long,
   output logic [NUM_CH*CNT_W-1:0] width,
   output logic                    err_any,
   output logic [NUM_CH*8-1:0]     err_cnt
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] MIN_V   = CNT_W'(MIN_CKS);
   localparam logic [CNT_W-1:0] MAX_V   = CNT_W'(MAX_CKS);
   // An over-long pulse reports MAX_CKS+1, clamped when that would not fit in CNT_W bits.
   localparam logic [CNT_W-1:0] LONG_V  = (MAX_CKS >= (2**CNT_W) - 1) ? CNT_MAX : CNT_W'(MAX_CKS + 1);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

   logic [NUM_CH-1:0] err_evt;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      state_t           state;
      logic [CNT_W-1:0] cnt;
      logic [CNT_W-1:0] width_q;
      logic             expr_q;
      logic             pass_q;
      logic             short_q;
      logic             long_q;
      logic             rise_d;
      logic             fall_d;
      logic             long_d;
      logic             short_d;

      assign rise_d  = ch_en[i] && expr[i] && !expr_q;
      assign fall_d  = ch_en[i] && (state == RUN) && !expr[i];
      assign long_d  = ch_en[i] && (state == RUN) && expr[i] && (UNBOUNDED == 0) && (cnt == MAX_V);
      assign short_d = fall_d && (cnt < MIN_V);
      assign err_evt[i] = short_d || long_d;

      always_ff @(posedge clk) begin
         if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            width_q <= '0;
            expr_q  <= 1'b1;
            pass_q  <= 1'b0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
         end else begin
            expr_q  <= expr[i];
            pass_q  <= 1'b0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            if (!ch_en[i]) begin
               // A disabled channel abandons any run silently and keeps its last width.
               state <= IDLE;
               cnt   <= '0;
            end else begin
               case (state)
                  IDLE: begin
                     if (rise_d) begin
                        state <= RUN;
                        cnt   <= CNT_W'(1);
                     end
                  end
                  RUN: begin
                     if (long_d) begin
                        long_q  <= 1'b1;
                        width_q <= LONG_V;
                        state   <= DRAIN;
                     end else if (fall_d) begin
                        width_q <= cnt;
                        short_q <= short_d;
                        pass_q  <= !short_d;
                        state   <= IDLE;
                     end else begin
                        cnt <= sat_inc(cnt);
                     end
                  end
                  DRAIN: begin
                     if (!expr[i]) state <= IDLE;
                  end
                  default: state <= IDLE;
               endcase
            end
         end
      end

      assign pass[i]                    = pass_q;
      assign err_short[i]               = short_q;
      assign err_long[i]                = long_q;
      assign width[i*CNT_W +: CNT_W]    = width_q;
   end

   // A new error in the same cycle as err_clr keeps the flag set.
   always_ff @(posedge clk) begin
      if (!reset_n)        err_any <= 1'b0;
      else if (|err_evt)   err_any <= 1'b1;
      else if (err_clr)    err_any <= 1'b0;
   end

`ifdef PULSE_WIDTH_MON_ERR_CNT_EN
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   for (genvar i = 0; i < NUM_CH; i++) begin : g_cnt
      logic [7:0] ecnt;

      always_ff @(posedge clk) begin
         if (!reset_n)        ecnt <= 8'd0;
         else if (err_clr)    ecnt <= err_evt[i] ? 8'd1 : 8'd0;
         else if (err_evt[i]) ecnt <= sat_inc8(ecnt);
      end

      assign err_cnt[i*8 +: 8] = ecnt;
   end
`else
   assign err_cnt = '0;
`endif

endmodule
